// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//
// Execute-stage controller for the 8-bit CPU. Accepts decoded instructions on a
// valid/ready handshake, reads operands from the R0..R3 register file, presents
// them to the external combinational ALU for one cycle (EXEC), captures the
// ALU result and flags, and writes both back one cycle later (WB).
//
// Optional feature macro: ALU_EXEC_FWD_EN
//   When defined, a new instruction may be accepted during WB. Operands whose
//   register matches the pending write-back destination take the result being
//   written instead of the stale register value.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready           instruction handshake
//   in_op/in_rd/in_rs           opcode, destination (= operand A), source B
//   in_use_imm/in_imm           select and value of the immediate operand B
//   alu_a/alu_b/alu_op          ALU operands and opcode (zero outside EXEC)
//   alu_cpu_flags               current architectural flags to the ALU
//   alu_c/alu_flags             ALU result and flags, captured in EXEC
//   wb_valid/wb_rd/wb_data      write-back strobe, destination and value
//   flags_q                     architectural flags register
//   dbg_addr/dbg_data           combinational register-file read port
// -----------------------------------------------------------------------------
module alu_exec_stage #(
   parameter int REGS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_op,
   input  logic [1:0] in_rd,
   input  logic [1:0] in_rs,
   input  logic       in_use_imm,
   input  logic [7:0] in_imm,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_op,
   output logic [7:0] alu_cpu_flags,
   input  logic [7:0] alu_c,
   input  logic [7:0] alu_flags,
   output logic       wb_valid,
   output logic [1:0] wb_rd,
   output logic [7:0] wb_data,
   output logic [7:0] flags_q,
   input  logic [1:0] dbg_addr,
   output logic [7:0] dbg_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t     state_q;
   logic [7:0] regs_q [REGS];
   logic [3:0] op_q;
   logic [1:0] rd_q;
   logic [7:0] a_q;
   logic [7:0] b_q;
   logic [7:0] res_q;
   logic [7:0] rflags_q;

   logic       accept;
   logic [7:0] a_d;
   logic [7:0] b_d;

   // Ready depends on state only, so it never combinationally follows in_valid.
   always_comb begin
`ifdef ALU_EXEC_FWD_EN
      in_ready = (state_q == IDLE) || (state_q == WB);
`else
      in_ready = (state_q == IDLE);
`endif
   end

   assign accept = in_valid && in_ready;

   // Operand selection at acceptance time.
   always_comb begin
      a_d = regs_q[in_rd];
      b_d = in_use_imm ? in_imm : regs_q[in_rs];
`ifdef ALU_EXEC_FWD_EN
      // During WB the register file still holds the old value of R[rd_q];
      // the value about to be written is res_q.
      if (state_q == WB) begin
         if (in_rd == rd_q) begin
            a_d = res_q;
         end
         if (!in_use_imm && (in_rs == rd_q)) begin
            b_d = res_q;
         end
      end
`endif
   end

   always_comb begin
      alu_a         = (state_q == EXEC) ? a_q  : 8'h00;
      alu_b         = (state_q == EXEC) ? b_q  : 8'h00;
      alu_op        = (state_q == EXEC) ? op_q : 4'h0;
      alu_cpu_flags = flags_q;
      wb_valid      = (state_q == WB);
      wb_rd         = (state_q == WB) ? rd_q  : 2'd0;
      wb_data       = (state_q == WB) ? res_q : 8'h00;
   end

   assign dbg_data = regs_q[dbg_addr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         for (int i = 0; i < REGS; i++) begin
            regs_q[i] <= 8'h00;
         end
         flags_q  <= 8'h00;
         op_q     <= 4'h0;
         rd_q     <= 2'd0;
         a_q      <= 8'h00;
         b_q      <= 8'h00;
         res_q    <= 8'h00;
         rflags_q <= 8'h00;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  op_q    <= in_op;
                  rd_q    <= in_rd;
                  a_q     <= a_d;
                  b_q     <= b_d;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               res_q    <= alu_c;
               rflags_q <= alu_flags;
               state_q  <= WB;
            end
            WB: begin
               // rd_q is read before any same-edge reload from a new accept.
               regs_q[rd_q] <= res_q;
               flags_q      <= rflags_q;
               if (accept) begin
                  op_q    <= in_op;
                  rd_q    <= in_rd;
                  a_q     <= a_d;
                  b_q     <= b_d;
                  state_q <= EXEC;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage
//
// Bench for alu_exec_stage. A small combinational ALU stands in for the real
// one. The driver keeps an architectural model (register array + flags) that is
// updated in program order at each acceptance and pushes the expected
// write-back into a queue; an independent monitor pops and compares whenever
// wb_valid is seen. Honours ALU_EXEC_FWD_EN for the expected issue spacing.
// -----------------------------------------------------------------------------
module tb_alu_exec_stage;

   // Bench-local ALU opcode map.
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_PASS = 4'd6;
   localparam logic [3:0] OP_INC  = 4'd5;

`ifdef ALU_EXEC_FWD_EN
   localparam int SPACE = 2;
`else
   localparam int SPACE = 3;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_op;
   logic [1:0] in_rd;
   logic [1:0] in_rs;
   logic       in_use_imm;
   logic [7:0] in_imm;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [3:0] alu_op;
   logic [7:0] alu_cpu_flags;
   logic [7:0] alu_c;
   logic [7:0] alu_flags;
   logic       wb_valid;
   logic [1:0] wb_rd;
   logic [7:0] wb_data;
   logic [7:0] flags_q;
   logic [1:0] dbg_addr;
   logic [7:0] dbg_data;

   alu_exec_stage #(.REGS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs),
      .in_use_imm(in_use_imm), .in_imm(in_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_cpu_flags(alu_cpu_flags),
      .alu_c(alu_c), .alu_flags(alu_flags),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .flags_q(flags_q),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Returns {flags, result}. Upper flag nibble mixes in the incoming flags so
   // the stage's cpu_flags path and verbatim flag storage are both exercised.
   function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] fin);
      logic [8:0] r;
      logic [7:0] f;
      case (op)
         4'd0:    r = {1'b0, a} + {1'b0, b};
         4'd1:    r = {1'b0, a} - {1'b0, b};
         4'd2:    r = {1'b0, a & b};
         4'd3:    r = {1'b0, a | b};
         4'd4:    r = {1'b0, a ^ b};
         4'd5:    r = {1'b0, a} + 9'd1;
         4'd6:    r = {1'b0, b};
         4'd7:    r = {1'b0, a} + {1'b0, b} + {8'd0, fin[0]};
         default: r = {1'b0, ~a ^ {op, op}};
      endcase
      f = {fin[7:4] ^ op, fin[3], r[7], (r[7:0] == 8'h00), r[8]};
      return {f, r[7:0]};
   endfunction

   always_comb begin
      {alu_flags, alu_c} = alu_f(alu_op, alu_a, alu_b, alu_cpu_flags);
   end

   typedef struct {
      logic [1:0] rd;
      logic [7:0] data;
      logic [7:0] flags;
      logic [7:0] old;
      int         wb_cyc;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] regs_m [4];
   logic [7:0] flags_m;
   int         checks = 0;
   int         errors = 0;
   bit         pend = 0;
   logic [1:0] pend_rd;
   logic [7:0] pend_data;
   logic [7:0] pend_flags;
   bit         have_prev = 0;
   int         last_acc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares every write-back against the scoreboard, then checks
   // the architectural effect one cycle later.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (pend) begin
            dbg_addr = pend_rd;
            #1;
            chk("dbg_after_wb", {24'd0, dbg_data}, {24'd0, pend_data});
            chk("flags_after_wb", {24'd0, flags_q}, {24'd0, pend_flags});
            pend = 0;
         end
         if (wb_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_wb_valid", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("wb_rd", {30'd0, wb_rd}, {30'd0, e.rd});
               chk("wb_data", {24'd0, wb_data}, {24'd0, e.data});
               chk("wb_latency_cycle", cyc, e.wb_cyc);
               chk("alu_idle_in_wb", {16'd0, alu_a, alu_b} | {28'd0, alu_op}, 32'd0);
               dbg_addr = e.rd;
               #1;
               chk("dbg_during_wb", {24'd0, dbg_data}, {24'd0, e.old});
               pend       = 1;
               pend_rd    = e.rd;
               pend_data  = e.data;
               pend_flags = e.flags;
            end
         end
      end
   end

   // Present one instruction at a negedge and hold it until accepted.
   task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic ui, input logic [7:0] imm, input int gap);
      bit         acc;
      logic [7:0] a;
      logic [7:0] b;
      logic [15:0] r;
      exp_t       e;
      acc = 0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_use_imm = ui; in_imm = imm;
      for (int w = 0; w < 10 && !acc; w++) begin
         if (in_ready) acc = 1;
         else @(negedge clk);
      end
      if (!acc) begin
         chk("accept_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      a = regs_m[rd];
      b = ui ? imm : regs_m[rs];
      r = alu_f(op, a, b, flags_m);
      e.rd = rd; e.data = r[7:0]; e.flags = r[15:8]; e.old = regs_m[rd];
      e.wb_cyc = cyc + 2;
      sb.push_back(e);
      regs_m[rd] = r[7:0];
      flags_m    = r[15:8];
      if (gap == 0 && have_prev) chk("issue_spacing", cyc + 1 - last_acc, SPACE);
      last_acc  = cyc + 1;
      have_prev = 1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("in_ready_low_in_exec", {31'd0, in_ready}, 32'd0);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && (sb.size() != 0 || pend); i++) @(negedge clk);
      repeat (2) @(negedge clk);
      have_prev = 0;
   endtask

   task automatic dbg_chk(input string name, input logic [1:0] r, input logic [7:0] exp);
      dbg_addr = r;
      #1;
      chk(name, {24'd0, dbg_data}, {24'd0, exp});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_op = 4'h0; in_rd = 2'd0; in_rs = 2'd0;
      in_use_imm = 1'b0; in_imm = 8'h00; dbg_addr = 2'd0;
      for (int i = 0; i < 4; i++) regs_m[i] = 8'h00;
      flags_m = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) dbg_chk("reset_reg", 2'(i), 8'h00);
      chk("reset_flags", {24'd0, flags_q}, 32'd0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_wb_valid", {31'd0, wb_valid}, 32'd0);

      // R1=0xCA, R2=0xAA, ADD r1,r2 -> 0x74
      issue(OP_PASS, 2'd1, 2'd0, 1'b1, 8'hCA, 0);
      issue(OP_PASS, 2'd2, 2'd0, 1'b1, 8'hAA, 0);
      issue(OP_ADD,  2'd1, 2'd2, 1'b0, 8'h00, 0);
      drain();
      dbg_chk("add_r1", 2'd1, 8'h74);

      // R1=0xCA, AND r1,#0x0F -> 0x0A
      issue(OP_PASS, 2'd1, 2'd0, 1'b1, 8'hCA, 0);
      issue(OP_AND,  2'd1, 2'd0, 1'b1, 8'h0F, 0);
      drain();
      dbg_chk("and_r1", 2'd1, 8'h0A);

      // Dependent increments back to back.
      issue(OP_PASS, 2'd0, 2'd0, 1'b1, 8'h01, 0);
      issue(OP_INC,  2'd0, 2'd0, 1'b0, 8'h00, 0);
      issue(OP_INC,  2'd0, 2'd0, 1'b0, 8'h00, 0);
      drain();
      dbg_chk("inc_inc_r0", 2'd0, 8'h03);

      // Reset during EXEC of SUB r3 abandons it.
      issue(OP_PASS, 2'd3, 2'd0, 1'b1, 8'h55, 0);
      drain();
      in_valid = 1'b1; in_op = OP_SUB; in_rd = 2'd3; in_rs = 2'd1; in_use_imm = 1'b0;
      chk("sub_ready_idle", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) regs_m[i] = 8'h00;
      flags_m = 8'h00;
      chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_mid_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_mid_flags", {24'd0, flags_q}, 32'd0);
      dbg_chk("rst_mid_r3", 2'd3, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #2;
         chk("rst_mid_no_wb", {31'd0, wb_valid}, 32'd0);
      end
      have_prev = 0;

      // Randomized instruction stream.
      for (int n = 0; n < 200; n++) begin
         issue(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 2)));
      end
      drain();
      for (int i = 0; i < 4; i++) dbg_chk("final_reg", 2'(i), regs_m[i]);
      chk("final_flags", {24'd0, flags_q}, {24'd0, flags_m});
      chk("scoreboard_empty", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute-stage controller for the 8-bit CPU, directly upstream and downstream of the combinational `alu`. It accepts decoded instructions over a valid/ready handshake and holds the four 8-bit general registers R0–R3 and the 8-bit flags register. It drives the ALU operand, opcode and `cpu_flags` inputs, captures `c`/`flags` one cycle later, and writes the result back.

## Interface
- `REGS`, 4: number of general registers (fixed at 4; the address is 2 bits).
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: synchronous active-low reset, sampled on the rising edge of `clk`.
- `in_valid` in 1: an instruction is presented.
- `in_ready` out 1: the stage can accept an instruction this cycle.
- `in_op` in 4: ALU opcode, using the ALU's `OP_*` encodings unmodified.
- `in_rd` in 2: destination register, also the source of operand A.
- `in_rs` in 2: source register for operand B.
- `in_use_imm` in 1: when 1, B is `in_imm` instead of R[`in_rs`].
- `in_imm` in 8: immediate operand.
- `alu_a`, `alu_b` out 8: ALU operands.
- `alu_op` out 4: ALU opcode.
- `alu_cpu_flags` out 8: current flags, passed to the ALU.
- `alu_c` in 8: ALU result.
- `alu_flags` in 8: ALU flags output.
- `wb_valid` out 1: a write-back is occurring this cycle.
- `wb_rd` out 2: write-back destination.
- `wb_data` out 8: write-back value.
- `flags_q` out 8: architectural flags register.
- `dbg_addr` in 2: debug read address.
- `dbg_data` out 8: combinational read of R[`dbg_addr`].

## Operation
- FSM states: IDLE, EXEC, WB.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `op_q`, `rd_q`, `a_q`=R[`in_rd`], `b_q`=`in_use_imm` ? `in_imm` : R[`in_rs`]. Go to EXEC.
- **EXEC**
  - `in_ready`=0.
  - `alu_a`=`a_q`, `alu_b`=`b_q`, `alu_op`=`op_q`, `alu_cpu_flags`=`flags_q`.
  - At the edge: `res_q`←`alu_c`, `rflags_q`←`alu_flags`. Go to WB.
- **WB**
  - `wb_valid`=1, `wb_rd`=`rd_q`, `wb_data`=`res_q`.
  - At the edge: R[`rd_q`]←`res_q`, `flags_q`←`rflags_q`.
  - Next state is IDLE, or EXEC if an instruction is accepted in this cycle (see Configuration).
- All opcodes write R[rd] and the flags, including unary ops. B is ignored by the ALU for unary ops; the stage does not special-case them.
- Flags are stored verbatim with no bit interpretation. Unused bits are passed through.
- Outside EXEC, `alu_a`/`alu_b`/`alu_op` are 0 and `alu_cpu_flags`=`flags_q`.
- In states other than WB, `wb_valid`=0 and `wb_rd`/`wb_data` are 0.
- `dbg_data` shows the pre-write value during WB. The new value is visible from the cycle after.

## Timing
- Accept edge E0 → EXEC during cycle E0..E1 → WB during cycle E1..E2 → register/flags update at E2.
- Write-back latency: 2 cycles from acceptance.
- Throughput: 1 instruction / 3 cycles without forwarding, 1 / 2 cycles with it.
- `in_ready` is a function of state only and never depends on `in_valid`.
- An instruction is accepted only on a cycle where both are high. A held `in_valid` with `in_ready`=0 is not consumed.
- Reset (`rst_n`=0 at an edge):
  - State → IDLE.
  - R0–R3, `flags_q`, `a_q`, `b_q`, `op_q`, `rd_q`, `res_q`, `rflags_q` → 0.
- Reset mid-operation (EXEC or WB) abandons the instruction with no write-back. Outputs show reset values from the following cycle: `in_ready`=1, `wb_valid`=0, `flags_q`=0.
- `rst_n` has priority over acceptance on the same edge.

## Configuration
- Macro: `ALU_EXEC_FWD_EN`.
- **Defined:**
  - `in_ready`=1 in IDLE and WB.
  - An instruction accepted in WB reads forwarded values:
    - A = `res_q` if `in_rd`==`rd_q`.
    - B = `res_q` if !`in_use_imm` && `in_rs`==`rd_q`.
    - Otherwise each operand comes from R[].
  - EXEC of that instruction sees `flags_q` already updated at the same edge.
- **Undefined:** `in_ready`=1 only in IDLE. No forwarding logic is built.

## Test plan
- Reset, then `dbg_addr` 0..3 → all `dbg_data`=0x00, `flags_q`=0x00, `in_ready`=1, `wb_valid`=0.
- Load an immediate (e.g. via a `use_imm` op that yields the immediate), then R1=0xCA, R2=0xAA, `OP_ADD` rd=1 rs=2 → `wb_valid` exactly 2 cycles after acceptance, `wb_data`=0x74, R1=0x74, `flags_q` equals the ALU flags sampled in EXEC.
- `OP_AND` rd=1 imm=0x0F with R1=0xCA → R1=0x0A. `dbg_data` on R1 reads 0xCA during WB and 0x0A one cycle later.
- Without `ALU_EXEC_FWD_EN`: keep `in_valid` high across two instructions → the second is accepted 3 cycles after the first and `in_ready` is low in EXEC/WB.
- With `ALU_EXEC_FWD_EN`: R0=0x01, `OP_INC` rd=0, then `OP_INC` rd=0 accepted in WB → R0=0x03 after the second write-back, 2-cycle spacing.
- Pull `rst_n` low during EXEC of `OP_SUB` rd=3 → no `wb_valid`, R3=0x00, `flags_q`=0x00, `in_ready`=1 the next cycle.
